// File: rtl/ctrl_pkg.sv
// Shared control-path definitions: opcode constants, FSM state encoding,
// datapath mux encodings and the instruction class type.
package ctrl_pkg;

   localparam logic [4:0] OPCODE_R      = 5'b01100;
   localparam logic [4:0] OPCODE_IARITH = 5'b00100;
   localparam logic [4:0] OPCODE_LOAD   = 5'b00000;
   localparam logic [4:0] OPCODE_STORE  = 5'b01000;
   localparam logic [4:0] OPCODE_BRANCH = 5'b11000;
   localparam logic [4:0] OPCODE_LUI    = 5'b01101;
   localparam logic [4:0] OPCODE_AUIPC  = 5'b00101;
   localparam logic [4:0] OPCODE_JAL    = 5'b11011;
   localparam logic [4:0] OPCODE_JALR   = 5'b11001;

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_TRAP   = 3'd5;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_BR    = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;
   localparam logic [1:0] ALU_IMM   = 2'b11;

   localparam logic       A_RS1 = 1'b0;
   localparam logic       A_PC  = 1'b1;

   localparam logic [1:0] B_RS2  = 2'd0;
   localparam logic [1:0] B_IMM  = 2'd1;
   localparam logic [1:0] B_FOUR = 2'd2;

   localparam logic [1:0] PC_PLUS4  = 2'd0;
   localparam logic [1:0] PC_TARGET = 2'd1;
   localparam logic [1:0] PC_ALU    = 2'd2;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC  = 2'd2;

   typedef enum logic [3:0] {
      CLS_NONE, CLS_R, CLS_IARITH, CLS_LOAD, CLS_STORE,
      CLS_BRANCH, CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR
   } instr_cls_t;

endpackage

// File: rtl/opcode_decoder.sv
// Opcode -> instruction class plus legal flag; shared with the single-cycle path.
// CTRL_JUMP_EN: when defined, JAL/JALR decode as legal jump classes; otherwise
// they fall into CLS_NONE and are treated as illegal.
module opcode_decoder
   import ctrl_pkg::*;
#(
   parameter int OPCODE_W = 5
) (
   input  logic [OPCODE_W-1:0] opcode,
   output instr_cls_t          cls,
   output logic                legal
);

   logic [4:0] op5;
   assign op5 = 5'(opcode);

   // map the opcode field onto an instruction class
   always_comb begin
      cls = CLS_NONE;
      case (op5)
         OPCODE_R:      cls = CLS_R;
         OPCODE_IARITH: cls = CLS_IARITH;
         OPCODE_LOAD:   cls = CLS_LOAD;
         OPCODE_STORE:  cls = CLS_STORE;
         OPCODE_BRANCH: cls = CLS_BRANCH;
         OPCODE_LUI:    cls = CLS_LUI;
         OPCODE_AUIPC:  cls = CLS_AUIPC;
`ifdef CTRL_JUMP_EN
         OPCODE_JAL:    cls = CLS_JAL;
         OPCODE_JALR:   cls = CLS_JALR;
`endif
         default:       cls = CLS_NONE;
      endcase
   end

   assign legal = (cls != CLS_NONE);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with a ready
// handshake on the shared memory port, bus timeout and sticky trap causes.
// CTRL_JUMP_EN enables JAL/JALR; without it those opcodes trap as illegal.
module multicycle_control_unit
   import ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int OPCODE_W    = 5
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [OPCODE_W-1:0] opcode_i,
   input  logic                mem_ready_i,
   input  logic                branch_taken_i,
   output logic                mem_req_o,
   output logic                mem_we_o,
   output logic                i_or_d_o,
   output logic                ir_wr_o,
   output logic                pc_wr_o,
   output logic [1:0]          pc_src_o,
   output logic [1:0]          alu_op_o,
   output logic                a_sel_o,
   output logic [1:0]          b_sel_o,
   output logic [1:0]          mem_to_reg_o,
   output logic                reg_wr_o,
   output logic [2:0]          state_o,
   output logic                trap_o,
   output logic                illegal_o,
   output logic                timeout_o
);

   // a zero timeout still needs a 1-bit counter so the declaration stays legal
   localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

   logic [2:0]          state_q, state_d;
   logic [OPCODE_W-1:0] opcode_q, dec_op;
   logic [CNT_W-1:0]    wait_q;
   logic                illegal_q, timeout_q;
   logic                mem_phase, wait_expired;
   instr_cls_t          cls;
   logic                legal;

   // DECODE decides legality from the live opcode; later states use the latched copy
   assign dec_op = (state_q == S_DECODE) ? opcode_i : opcode_q;

   opcode_decoder #(.OPCODE_W(OPCODE_W)) u_dec (
      .opcode (dec_op),
      .cls    (cls),
      .legal  (legal)
   );

   assign mem_phase    = (state_q == S_FETCH) || (state_q == S_MEM);
   assign wait_expired = (MEM_TIMEOUT > 0) && mem_phase && !mem_ready_i &&
                         (int'(wait_q) == MEM_TIMEOUT - 1);

   // next-state logic; a ready in the expiry cycle wins over the timeout
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:  if (mem_ready_i) state_d = S_DECODE;
                   else if (wait_expired) state_d = S_TRAP;
         S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
         S_EXEC:   case (cls)
                      CLS_BRANCH:          state_d = S_FETCH;
                      CLS_LOAD, CLS_STORE: state_d = S_MEM;
                      default:             state_d = S_WB;
                   endcase
         S_MEM:    if (mem_ready_i) state_d = (cls == CLS_LOAD) ? S_WB : S_FETCH;
                   else if (wait_expired) state_d = S_TRAP;
         S_WB:     state_d = S_FETCH;
         S_TRAP:   state_d = S_TRAP;
         default:  state_d = S_FETCH;
      endcase
   end

   // state, latched opcode, wait counter and sticky trap causes
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_FETCH;
         opcode_q  <= '0;
         wait_q    <= '0;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE) opcode_q <= opcode_i;
         if (state_d != state_q) wait_q <= '0;
         else if (mem_phase && !mem_ready_i) wait_q <= wait_q + CNT_W'(1);
         if (state_q == S_DECODE && !legal) illegal_q <= 1'b1;
         if (wait_expired) timeout_q <= 1'b1;
      end
   end

   // datapath controls decoded from state and class; forced low during reset
   always_comb begin
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      i_or_d_o     = 1'b0;
      ir_wr_o      = 1'b0;
      pc_wr_o      = 1'b0;
      pc_src_o     = PC_PLUS4;
      alu_op_o     = ALU_ADD;
      a_sel_o      = A_RS1;
      b_sel_o      = B_RS2;
      mem_to_reg_o = WB_ALU;
      reg_wr_o     = 1'b0;
      if (!rst_i) begin
         case (state_q)
            S_FETCH: begin
               mem_req_o = 1'b1;
               a_sel_o   = A_PC;
               b_sel_o   = B_FOUR;
               ir_wr_o   = mem_ready_i;
               pc_wr_o   = mem_ready_i;
            end
            S_EXEC: case (cls)
               CLS_R:      alu_op_o = ALU_FUNCT;
               CLS_IARITH: begin alu_op_o = ALU_FUNCT; b_sel_o = B_IMM; end
               CLS_LOAD, CLS_STORE: b_sel_o = B_IMM;
               CLS_BRANCH: begin
                  alu_op_o = ALU_BR;
                  pc_src_o = PC_TARGET;
                  pc_wr_o  = branch_taken_i;
               end
               CLS_LUI:    begin alu_op_o = ALU_IMM; b_sel_o = B_IMM; end
               CLS_AUIPC:  begin a_sel_o = A_PC; b_sel_o = B_IMM; end
`ifdef CTRL_JUMP_EN
               CLS_JAL:    begin pc_src_o = PC_TARGET; pc_wr_o = 1'b1; end
               CLS_JALR:   begin b_sel_o = B_IMM; pc_src_o = PC_ALU; pc_wr_o = 1'b1; end
`endif
               default: ;
            endcase
            S_MEM: begin
               mem_req_o = 1'b1;
               i_or_d_o  = 1'b1;
               mem_we_o  = (cls == CLS_STORE);
               b_sel_o   = B_IMM;
            end
            S_WB: begin
               reg_wr_o = 1'b1;
               if (cls == CLS_LOAD) mem_to_reg_o = WB_MEM;
`ifdef CTRL_JUMP_EN
               else if (cls == CLS_JAL || cls == CLS_JALR) mem_to_reg_o = WB_PC;
`endif
            end
            default: ;
         endcase
      end
   end

   assign state_o   = rst_i ? S_FETCH : state_q;
   assign trap_o    = !rst_i && (state_q == S_TRAP);
   assign illegal_o = !rst_i && illegal_q;
   assign timeout_o = !rst_i && timeout_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: a per-instruction reference model expands each randomized
// instruction into its expected cycle-by-cycle control trace; a monitor pops
// and compares one expected vector per cycle.
module tb_multicycle_control_unit;

   localparam int TO = 4;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic [4:0] opcode_i;
   logic       mem_ready_i, branch_taken_i;
   logic       mem_req_o, mem_we_o, i_or_d_o, ir_wr_o, pc_wr_o, a_sel_o, reg_wr_o;
   logic [1:0] pc_src_o, alu_op_o, b_sel_o, mem_to_reg_o;
   logic [2:0] state_o;
   logic       trap_o, illegal_o, timeout_o;

   multicycle_control_unit #(.MEM_TIMEOUT(TO), .OPCODE_W(5)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .mem_ready_i(mem_ready_i),
      .branch_taken_i(branch_taken_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
      .i_or_d_o(i_or_d_o), .ir_wr_o(ir_wr_o), .pc_wr_o(pc_wr_o), .pc_src_o(pc_src_o),
      .alu_op_o(alu_op_o), .a_sel_o(a_sel_o), .b_sel_o(b_sel_o),
      .mem_to_reg_o(mem_to_reg_o), .reg_wr_o(reg_wr_o), .state_o(state_o),
      .trap_o(trap_o), .illegal_o(illegal_o), .timeout_o(timeout_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic mem_req, mem_we, i_or_d, ir_wr, pc_wr;
      logic [1:0] pc_src, alu_op;
      logic a_sel;
      logic [1:0] b_sel, mem_to_reg;
      logic reg_wr;
      logic [2:0] state;
      logic trap, illegal, timeout;
   } outs_t;

   typedef struct {
      logic       rst;
      logic [4:0] opc;
      logic       rdy, tk;
      outs_t      e;
      string      tag;
   } cyc_t;

   outs_t act;
   assign act = {mem_req_o, mem_we_o, i_or_d_o, ir_wr_o, pc_wr_o, pc_src_o, alu_op_o,
                 a_sel_o, b_sel_o, mem_to_reg_o, reg_wr_o, state_o, trap_o,
                 illegal_o, timeout_o};

   cyc_t  plan[$];
   outs_t expq[$];
   string tagq[$];
   int    checks = 0, failures = 0;

   localparam logic [4:0] R = 5'b01100, IA = 5'b00100, LD = 5'b00000, ST = 5'b01000,
                          BR = 5'b11000, LUI = 5'b01101, AUI = 5'b00101,
                          JAL = 5'b11011, JALR = 5'b11001;

   function automatic logic [4:0] rop();
      return 5'($urandom);
   endfunction

   function automatic logic rb();
      return 1'($urandom);
   endfunction

   function automatic bit is_legal(logic [4:0] o);
      if (o inside {R, IA, LD, ST, BR, LUI, AUI}) return 1;
`ifdef CTRL_JUMP_EN
      if (o == JAL || o == JALR) return 1;
`endif
      return 0;
   endfunction

   function automatic void add(logic r, logic [4:0] o, logic rd, logic t, outs_t e, string tag);
      cyc_t c;
      c.rst = r; c.opc = o; c.rdy = rd; c.tk = t; c.e = e; c.tag = tag;
      plan.push_back(c);
   endfunction

   function automatic void add_trap(logic ill, logic tmo);
      outs_t e;
      for (int i = 0; i < 20; i++) begin
         e = '0; e.state = 3'd5; e.trap = 1'b1; e.illegal = ill; e.timeout = tmo;
         add(1'b0, rop(), rb(), rb(), e, "trap_hold");
      end
   endfunction

   // expected trace of one instruction, phase by phase; fw/mw are ready delays
   function automatic void build(logic [4:0] o, logic t, int fw, int mw);
      outs_t e;
      int n;
      n = (fw >= TO) ? TO : fw;
      for (int i = 0; i < n; i++) begin
         e = '0; e.mem_req = 1; e.a_sel = 1; e.b_sel = 2'd2;
         add(1'b0, rop(), 1'b0, rb(), e, "fetch_wait");
      end
      if (fw >= TO) begin add_trap(1'b0, 1'b1); return; end
      e = '0; e.mem_req = 1; e.a_sel = 1; e.b_sel = 2'd2; e.ir_wr = 1; e.pc_wr = 1;
      add(1'b0, rop(), 1'b1, rb(), e, "fetch_done");
      e = '0; e.state = 3'd1;
      add(1'b0, o, rb(), rb(), e, "decode");
      if (!is_legal(o)) begin add_trap(1'b1, 1'b0); return; end
      e = '0; e.state = 3'd2;
      case (o)
         R:    e.alu_op = 2'b10;
         IA:   begin e.alu_op = 2'b10; e.b_sel = 2'd1; end
         LD, ST: e.b_sel = 2'd1;
         BR:   begin e.alu_op = 2'b01; e.pc_src = 2'd1; e.pc_wr = t; end
         LUI:  begin e.alu_op = 2'b11; e.b_sel = 2'd1; end
         AUI:  begin e.a_sel = 1; e.b_sel = 2'd1; end
         JAL:  begin e.pc_src = 2'd1; e.pc_wr = 1; end
         JALR: begin e.b_sel = 2'd1; e.pc_src = 2'd2; e.pc_wr = 1; end
         default: ;
      endcase
      add(1'b0, rop(), rb(), t, e, "exec");
      if (o == BR) return;
      if (o == LD || o == ST) begin
         e = '0; e.state = 3'd3; e.mem_req = 1; e.i_or_d = 1; e.b_sel = 2'd1;
         e.mem_we = (o == ST);
         n = (mw >= TO) ? TO : mw;
         for (int i = 0; i < n; i++) add(1'b0, rop(), 1'b0, rb(), e, "mem_wait");
         if (mw >= TO) begin add_trap(1'b0, 1'b1); return; end
         add(1'b0, rop(), 1'b1, rb(), e, "mem_done");
         if (o == ST) return;
      end
      e = '0; e.state = 3'd4; e.reg_wr = 1;
      e.mem_to_reg = (o == LD) ? 2'd1 : (o == JAL || o == JALR) ? 2'd2 : 2'd0;
      add(1'b0, rop(), rb(), rb(), e, "wb");
   endfunction

   task automatic play();
      while (plan.size() > 0) begin
         cyc_t c;
         c = plan.pop_front();
         rst_i = c.rst; opcode_i = c.opc; mem_ready_i = c.rdy; branch_taken_i = c.tk;
         expq.push_back(c.e); tagq.push_back(c.tag);
         @(posedge clk_i); #1;
      end
   endtask

   // abort < 0: run to completion; otherwise reset after that many cycles
   task automatic run(logic [4:0] o, logic t, int fw, int mw, int abort);
      plan.delete();
      build(o, t, fw, mw);
      if (abort >= 0 && abort < plan.size()) begin
         while (plan.size() > abort) void'(plan.pop_back());
         add(1'b1, rop(), rb(), rb(), '0, "reset_abort");
      end else if (plan[$].e.trap) begin
         add(1'b1, rop(), rb(), rb(), '0, "reset_trap");
      end
      play();
   endtask

   // one comparison per cycle that has an expected vector queued
   always @(negedge clk_i) begin
      if (expq.size() > 0) begin
         outs_t e;
         string tg;
         e = expq.pop_front();
         tg = tagq.pop_front();
         checks++;
         if (act !== e) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tg, act, e, $time);
         end
      end
   end

   initial begin
      logic [4:0] legal_ops [9];
      logic [4:0] o;
      int fw, mw, ab;
      legal_ops = '{R, IA, LD, ST, BR, LUI, AUI, JAL, JALR};
      rst_i = 1'b1; opcode_i = '0; mem_ready_i = 1'b0; branch_taken_i = 1'b0;
      @(posedge clk_i); #1;
      plan.delete();
      add(1'b1, rop(), rb(), rb(), '0, "reset_init");
      add(1'b1, rop(), rb(), rb(), '0, "reset_init");
      play();

      run(R,   0, 0, 0, -1);
      run(LD,  0, 0, 3, -1);
      run(BR,  1, 0, 0, -1);
      run(BR,  0, 0, 0, -1);
      run(IA,  0, TO-1, 0, -1);
      run(R,   0, TO, 0, -1);
      run(5'b11111, 0, 0, 0, -1);
      run(JAL, 0, 0, 0, -1);
      run(JALR, 0, 1, 0, -1);
      run(LUI, 0, 0, 0, -1);
      run(AUI, 0, 2, 0, -1);
      run(ST,  0, 0, 2, 3);
      run(ST,  0, 0, TO-1, -1);
      run(LD,  0, 0, TO, -1);

      for (int k = 0; k < 200; k++) begin
         o  = ($urandom_range(0, 9) < 9) ? legal_ops[$urandom_range(0, 8)] : rop();
         fw = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(3, 5);
         mw = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(3, 5);
         ab = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 8) : -1;
         run(o, rb(), fw, mw, ab);
      end

      repeat (3) @(posedge clk_i);
      checks++;
      if (expq.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending expected 0", expq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Sequential multi-cycle control unit for the RV32I core. It sequences every instruction through FETCH/DECODE/EXEC/MEM/WB phases over a shared memory port with a ready handshake, and drives the datapath mux and enable signals for each phase. It sits between the instruction register's opcode field, the branch comparator and the memory interface. It extends the single-cycle decode set with I-type arithmetic, JAL/JALR, memory wait states, a bus timeout and a trap state.

## Interface
- MEM_TIMEOUT, 16: maximum cycles to wait for `mem_ready_i` in FETCH or MEM; 0 disables the timeout.
- OPCODE_W, 5: opcode field width (instr[6:2]).
- clk_i  in  1  clock; every register updates on its rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- opcode_i  in  OPCODE_W  instr[6:2] from the instruction register.
- mem_ready_i  in  1  memory completes the current request this cycle.
- branch_taken_i  in  1  branch comparator result, valid in EXEC.
- mem_req_o  out  1  memory request, held until ready.
- mem_we_o  out  1  write strobe qualifying `mem_req_o`.
- i_or_d_o  out  1  memory address select: 0 = PC, 1 = ALU result.
- ir_wr_o  out  1  instruction register and old_pc load.
- pc_wr_o  out  1  PC load enable.
- pc_src_o  out  2  PC source: 0 = PC+4 (ALU), 1 = target adder (old_pc+imm), 2 = ALU result & ~1.
- alu_op_o  out  2  00 = add, 01 = branch compare, 10 = funct-decoded, 11 = pass immediate.
- a_sel_o  out  1  ALU A: 0 = rs1, 1 = PC in FETCH or old_pc otherwise.
- b_sel_o  out  2  ALU B: 0 = rs2, 1 = immediate, 2 = constant 4.
- mem_to_reg_o  out  2  write-back source: 0 = ALU, 1 = memory, 2 = PC (already old_pc+4).
- reg_wr_o  out  1  register-file write enable.
- state_o  out  3  current state, for debug.
- trap_o  out  1  in TRAP.
- illegal_o  out  1  trap cause is an undecoded opcode, sticky.
- timeout_o  out  1  trap cause is a memory timeout, sticky.

## Operation
- State encoding: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 5.
- Outputs are decoded from the state register and the latched opcode. Every output is 0 in any state or cycle not listed below.
- **FETCH:** drives `mem_req_o` = 1, `i_or_d_o` = 0, `a_sel_o` = 1, `b_sel_o` = 2, `alu_op_o` = 00.
  - On `mem_ready_i`: `ir_wr_o` = 1, `pc_wr_o` = 1, `pc_src_o` = 0, next state DECODE.
- **DECODE:** latches `opcode_i` into opcode_q.
  - Legal opcodes go to EXEC: R (01100), I-arith (00100), Load (00000), Store (01000), Branch (11000), LUI (01101), AUIPC (00101), JAL (11011), JALR (11001).
  - Any other opcode goes to TRAP and sets `illegal_o`.
- **EXEC signals by class:**
  - R: `alu_op_o` = 10 → WB.
  - I-arith: `alu_op_o` = 10, `b_sel_o` = 1 → WB.
  - Load/Store: `alu_op_o` = 00, `b_sel_o` = 1 → MEM.
  - Branch: `alu_op_o` = 01, `pc_src_o` = 1, `pc_wr_o` = `branch_taken_i` → FETCH.
  - LUI: `alu_op_o` = 11, `b_sel_o` = 1 → WB.
  - AUIPC: `a_sel_o` = 1, `b_sel_o` = 1, `alu_op_o` = 00 → WB.
  - JAL: `pc_src_o` = 1, `pc_wr_o` = 1 → WB.
  - JALR: `alu_op_o` = 00, `b_sel_o` = 1, `pc_src_o` = 2, `pc_wr_o` = 1 → WB.
- **MEM:** drives `mem_req_o` = 1, `i_or_d_o` = 1, `mem_we_o` = store. ALU controls are held at their EXEC values.
  - On `mem_ready_i`: Load → WB, Store → FETCH.
- **WB:** `reg_wr_o` = 1. `mem_to_reg_o` = 1 for Load, 2 for JAL/JALR, 0 otherwise. Next state FETCH.
- **TRAP:** all control outputs 0, `trap_o` = 1. Stays in TRAP until `rst_i`.
- **Wait counter** (width $clog2(MEM_TIMEOUT+1)):
  - Clears on entry to FETCH or MEM; increments each cycle in those states while `mem_ready_i` = 0.
  - With MEM_TIMEOUT > 0 and the counter at MEM_TIMEOUT-1 with `mem_ready_i` = 0, next state is TRAP and `timeout_o` sets.
  - `mem_ready_i` in that same cycle wins: normal transition, no trap.
- `branch_taken_i` is ignored outside EXEC. `mem_ready_i` is ignored outside FETCH and MEM.

## Timing
- Reset: while `rst_i` is high, all outputs are 0, `state_o` = 0, and the counter, opcode_q, `illegal_o` and `timeout_o` clear. FETCH begins in the first cycle after deassertion.
- Reset mid-instruction aborts it. No further `reg_wr_o`, `pc_wr_o` or `mem_we_o` pulses occur in the cycle after `rst_i` is sampled.
- Cycle counts with zero-wait memory (ready in the request cycle):
  - Branch: 3.
  - R, I-arith, LUI, AUIPC, JAL, JALR, Store: 4.
  - Load: 5.
- Each memory wait cycle adds 1.

## Configuration
- CTRL_JUMP_EN defined: JAL/JALR decode as specified above.
- CTRL_JUMP_EN undefined: opcodes 11011 and 11001 go to TRAP with `illegal_o`. `pc_src_o` never equals 2 and `mem_to_reg_o` never equals 2.

## Structure
- Shared package ctrl_pkg holds:
  - OPCODE_* constants.
  - State encoding.
  - alu_op, a_sel, b_sel, pc_src and mem_to_reg encodings.
- Sub-module opcode_decoder: combinational opcode_q → instruction class plus legal flag. It is shared with the single-cycle path.

## Test plan
- R-type 01100, `mem_ready_i` = 1 held → `state_o` 0,1,2,4; `alu_op_o` = 10 in EXEC; `reg_wr_o` = 1 only in cycle 4; FETCH in cycle 5.
- Load 00000, ready withheld 3 cycles in MEM → `mem_req_o` = 1 and `i_or_d_o` = 1 for 4 cycles; WB with `mem_to_reg_o` = 1; total 8 cycles.
- Branch 11000 with `branch_taken_i` = 1 → in EXEC `pc_wr_o` = 1, `pc_src_o` = 1; repeat with 0 → `pc_wr_o` = 0; 3 cycles each; `reg_wr_o` never asserted.
- MEM_TIMEOUT = 4, `mem_ready_i` = 0 → TRAP after 4 FETCH cycles, `trap_o` = `timeout_o` = 1, held 20 cycles until `rst_i`.
- Opcode 11111 → TRAP after DECODE, `illegal_o` = 1. JAL with CTRL_JUMP_EN undefined → same result. JAL with it defined → `pc_wr_o`/`pc_src_o` = 1 in EXEC, then `mem_to_reg_o` = 2 in WB.
- Store with `rst_i` pulsed during MEM before ready → no `mem_we_o` in the following cycle; FETCH with all flags clear after release.
